fp_normalizer: RTL and testbench

- 3-stage pipelined post-addition normalizer for the double-precision floating-point adder datapath.
- Consumes the raw significand sum and the pre-normalization exponent produced by the add/subtract stage.
- Computes the leading-zero count, then applies it: left-shifts the significand and decrements the exponent.
- Also handles carry-out right shift, gradual underflow to subnormal, zero and exponent overflow. Rounding is out of scope (truncation).

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_normalizer_lzc53.sv | 15 +
 rtl/fp_normalizer.sv | 161 ++++++++++++++++
 tb/tb_fp_normalizer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths and beat types for the double-precision normalizer
package fp_pkg;

    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int MANT_W = FRAC_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
    localparam int BIAS = 1023;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_norm_in_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              zero;
        logic              denorm;
        logic              inf;
    } fp_norm_out_t;

endpackage

// File: rtl/fp_normalizer_lzc53.sv
// rtl/fp_normalizer_lzc53.sv - combinational 53-bit leading-zero counter
module lzc53 (
    input  logic [52:0] d,
    output logic [5:0]  cnt
);

    // Scanning upward lets the highest set bit make the final assignment.
    always_comb begin
        cnt = 6'd53;
        for (int i = 0; i < 53; i++) begin
            if (d[i]) cnt = 6'(52 - i);
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - 3-stage post-addition normalizer (carry, lzc shift, subnormal, overflow)
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W+1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_zero,
    output logic              out_denorm,
    output logic              out_inf
);

    localparam int SIG_W = FRAC_W + 1;
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_TOP = {1'b0, {EXP_W{1'b1}}};

    logic         en;
    fp_norm_in_t  beat;
    fp_norm_out_t res;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign beat     = '{sign: in_sign, exp: in_exp, mant: in_mant};

    // Stage 1: subnormal scale fix-up and carry-out right shift
    logic [EXP_W:0] e0, e1;
    logic [SIG_W-1:0] m1;
    logic inf1;

    always_comb begin
        e0   = (beat.exp == '0) ? EXP_ONE : {1'b0, beat.exp};
        e1   = e0;
        m1   = beat.mant[SIG_W-1:0];
        inf1 = 1'b0;
        if (beat.mant[FRAC_W+1]) begin
            e1   = e0 + EXP_ONE;
            m1   = beat.mant[FRAC_W+1:1];
            inf1 = (e1 >= EXP_TOP);
        end
    end

    logic             s1_valid, s1_sign, s1_inf;
    logic [EXP_W:0]   s1_exp;
    logic [SIG_W-1:0] s1_mant;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= beat.sign;
            s1_inf   <= inf1;
            s1_exp   <= e1;
            s1_mant  <= m1;
        end
    end

    // Stage 2: pick the shift amount, clamping at the subnormal boundary
    logic [5:0]       lz;
    logic [EXP_W:0]   lz_ext, exp_diff, exp_less1;
    logic [5:0]       shift2;
    logic [EXP_W-1:0] exp2;
    logic             zero2, denorm2;

    lzc53 u_lzc (
        .d   (s1_mant),
        .cnt (lz)
    );

    assign lz_ext    = {{(EXP_W-5){1'b0}}, lz};
    assign exp_diff  = s1_exp - lz_ext;
    assign exp_less1 = s1_exp - EXP_ONE;

    always_comb begin
        shift2  = '0;
        exp2    = '0;
        zero2   = 1'b0;
        denorm2 = 1'b0;
        if (s1_inf) begin
            exp2 = EXP_MAX;
        end else if (s1_mant == '0) begin
            zero2 = 1'b1;
        end else if (lz_ext < s1_exp) begin
            shift2 = lz;
            exp2   = exp_diff[EXP_W-1:0];
        end else begin
            shift2  = exp_less1[5:0];
            denorm2 = 1'b1;
        end
    end

    logic             s2_valid, s2_sign, s2_zero, s2_denorm, s2_inf;
    logic [EXP_W-1:0] s2_exp;
    logic [5:0]       s2_shift;
    logic [SIG_W-1:0] s2_mant;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_denorm <= 1'b0;
            s2_inf    <= 1'b0;
            s2_exp    <= '0;
            s2_shift  <= '0;
            s2_mant   <= '0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_zero   <= zero2;
            s2_denorm <= denorm2;
            s2_inf    <= s1_inf;
            s2_exp    <= exp2;
            s2_shift  <= shift2;
            s2_mant   <= s1_mant;
        end
    end

    // Stage 3: apply the shift and drop the hidden bit
    logic [SIG_W-1:0] shifted;
    assign shifted = s2_mant << s2_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
        end else if (en) begin
            out_valid  <= s2_valid;
            res.sign   <= s2_sign;
            res.exp    <= s2_exp;
            res.frac   <= s2_inf ? '0 : shifted[FRAC_W-1:0];
            res.zero   <= s2_zero;
            res.denorm <= s2_denorm;
            res.inf    <= s2_inf;
        end
    end

    assign out_sign   = res.sign;
    assign out_exp    = res.exp;
    assign out_frac   = res.frac;
    assign out_zero   = res.zero;
    assign out_denorm = res.denorm;
    assign out_inf    = res.inf;

endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - scoreboard bench for fp_normalizer with directed vectors
module tb_fp_normalizer;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [10:0] in_exp = '0;
    logic [53:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [10:0] out_exp;
    logic [51:0] out_frac;
    logic        out_zero, out_denorm, out_inf;

    int total = 0;
    int bad = 0;
    int beat_no = 0;
    fp_norm_out_t sb[$];

    always #5 clk = ~clk;

    fp_normalizer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
        .out_zero(out_zero), .out_denorm(out_denorm), .out_inf(out_inf)
    );

    function automatic fp_norm_out_t cur_out();
        fp_norm_out_t r;
        r.sign = out_sign; r.exp = out_exp; r.frac = out_frac;
        r.zero = out_zero; r.denorm = out_denorm; r.inf = out_inf;
        return r;
    endfunction

    function automatic fp_norm_out_t mk(input logic s, input logic [10:0] e, input logic [51:0] f,
                                        input logic z, input logic d, input logic i);
        fp_norm_out_t r;
        r.sign = s; r.exp = e; r.frac = f; r.zero = z; r.denorm = d; r.inf = i;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic send(input logic s, input logic [10:0] e, input logic [53:0] m, input fp_norm_out_t x);
        bit done = 0;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(x);
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: a pop happens on the next rising edge whenever valid and ready are both high.
    initial begin
        fp_norm_out_t got, want;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                got = cur_out();
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat actual=s%0b e%0d f%0h z%0b d%0b i%0b required=none",
                             got.sign, got.exp, got.frac, got.zero, got.denorm, got.inf);
                end else begin
                    want = sb.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL beat%0d actual=s%0b e%0d f%0h z%0b d%0b i%0b required=s%0b e%0d f%0h z%0b d%0b i%0b",
                                 beat_no, got.sign, got.exp, got.frac, got.zero, got.denorm, got.inf,
                                 want.sign, want.exp, want.frac, want.zero, want.denorm, want.inf);
                    end
                end
                beat_no++;
            end
        end
    end

    initial begin
        fp_norm_out_t snap;
        int lat;
        bit seen;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_data", 64'({out_sign, out_exp, out_zero, out_denorm, out_inf}), 64'd0);
        chk("reset_out_frac", 64'(out_frac), 64'd0);
        @(posedge clk); #1;

        send(0, 11'd1023, 54'd1 << 52,                mk(0, 11'd1023, 52'd0, 0, 0, 0));
        send(1, 11'd1023, (54'd1 << 53) | 54'd2,      mk(1, 11'd1024, 52'd1, 0, 0, 0));
        send(0, 11'd1023, 54'd1,                      mk(0, 11'd971, 52'd0, 0, 0, 0));
        send(0, 11'd5,    54'd1 << 40,                mk(0, 11'd0, 52'd1 << 44, 0, 1, 0));
        send(1, 11'd500,  54'd0,                      mk(1, 11'd0, 52'd0, 1, 0, 0));
        send(1, 11'd2046, (54'd1 << 53) | (54'd1 << 5), mk(1, 11'd2047, 52'd0, 0, 0, 1));
        send(0, 11'd0,    54'd1 << 52,                mk(0, 11'd1, 52'd0, 0, 0, 0));
        send(0, 11'd0,    (54'd1 << 51) | 54'd3,      mk(0, 11'd0, (52'd1 << 51) | 52'd3, 0, 1, 0));
        send(0, 11'd4,    54'd1 << 49,                mk(0, 11'd1, 52'd0, 0, 0, 0));
        send(0, 11'd3,    54'd1 << 49,                mk(0, 11'd0, 52'd1 << 51, 0, 1, 0));
        send(0, 11'd2045, (54'd1 << 53) | (54'd1 << 10), mk(0, 11'd2046, 52'd1 << 9, 0, 0, 0));
        send(1, 11'd1023, (54'd1 << 53) | 54'd1,      mk(1, 11'd1024, 52'd0, 0, 0, 0));
        in_valid = 1'b0;
        drain();

        // Latency from an idle pipe: the accept edge counts as the first of three.
        send(0, 11'd7, (54'd1 << 52) | 54'd5, mk(0, 11'd7, 52'd5, 0, 0, 0));
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd3);
        drain();

        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(i[0], 11'(100 + i), (54'd1 << 52) | 54'(i + 1),
                         mk(i[0], 11'(100 + i), 52'(i + 1), 0, 0, 0));
                in_valid = 1'b0;
            end
            begin
                seen = 0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(posedge clk); #1;
                    if (out_valid) seen = 1;
                end
                chk("stall_out_valid_seen", 64'(seen), 64'd1);
                out_ready = 1'b0;
                snap = cur_out();
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    total++;
                    if (cur_out() !== snap) begin
                        bad++;
                        $display("FAIL stall_hold actual=e%0d f%0h required=e%0d f%0h",
                                 out_exp, out_frac, snap.exp, snap.frac);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        send(0, 11'd300, 54'd1 << 52, mk(0, 11'd300, 52'd0, 0, 0, 0));
        send(1, 11'd301, 54'd1 << 52, mk(1, 11'd301, 52'd0, 0, 0, 0));
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        send(1, 11'd1023, 54'd1 << 46, mk(1, 11'd1017, 52'd0, 0, 0, 0));
        in_valid = 1'b0;
        drain();
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
